dmux_1to4: RTL and testbench

Registered 1-to-N demultiplexer: routes a single input `i_in` to exactly one output lane of `y`, chosen by select `s`, when `enable` is high. All other lanes drive zero. With default parameters it is a 1-to-4, 1-bit-wide demux. It sits on the datapath wherever one source fans out to one of several sinks, with the outputs registered for clean timing.

---
 rtl/dmux_pkg.sv | 12 +
 rtl/dmux_decoder.sv | 19 +
 rtl/dmux_1to4.sv | 42 ++++
 tb/tb_dmux_1to4.sv | 138 +++++++++++++
 4 files changed

// File: rtl/dmux_pkg.sv
// Shared defaults and lane-slicing helper for the registered demultiplexer.
package dmux_pkg;

    localparam int DEFAULT_SEL_W  = 2;
    localparam int DEFAULT_DATA_W = 1;

    // Low bit of lane k within a flattened bus of data_w-wide lanes.
    function automatic int lane_lo(input int k, input int data_w);
        return k * data_w;
    endfunction

endpackage

// File: rtl/dmux_decoder.sv
// Combinational one-hot decode of the lane select, gated by enable.
module dmux_decoder
    import dmux_pkg::*;
#(
    parameter int SEL_W = DEFAULT_SEL_W
) (
    input  logic                  enable,
    input  logic [SEL_W-1:0]      s,
    output logic [(2**SEL_W)-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (enable) begin
            onehot[s] = 1'b1;
        end
    end

endmodule

// File: rtl/dmux_1to4.sv
// Registered 1-to-N demux: i_in is routed to lane s when enabled, every other lane is zero.
module dmux_1to4
    import dmux_pkg::*;
#(
    parameter int SEL_W  = DEFAULT_SEL_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [DATA_W-1:0]                i_in,
    input  logic [SEL_W-1:0]                 s,
    output logic [((2**SEL_W)*DATA_W)-1:0]   y
);

    localparam int N_OUT = 2 ** SEL_W;

    logic [N_OUT-1:0]        onehot;
    logic [N_OUT*DATA_W-1:0] y_next;

    dmux_decoder #(
        .SEL_W (SEL_W)
    ) u_decoder (
        .enable (enable),
        .s      (s),
        .onehot (onehot)
    );

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        assign y_next[lane_lo(k, DATA_W) +: DATA_W] = i_in & {DATA_W{onehot[k]}};
    end

    // Whole bus updates on one edge, so a lane switch never shows two lanes active.
    always_ff @(posedge clk) begin
        if (rst) begin
            y <= '0;
        end else begin
            y <= y_next;
        end
    end

endmodule

// File: tb/tb_dmux_1to4.sv
// Directed, table-driven bench for dmux_1to4 at default and widened parameters.
module tb_dmux_1to4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [0:0] i_in;
    logic [1:0] s;
    logic [3:0] y;

    logic        rst_w;
    logic        enable_w;
    logic [3:0]  i_in_w;
    logic [2:0]  s_w;
    logic [31:0] y_w;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic       rst;
        logic       enable;
        logic       i_in;
        logic [1:0] s;
        logic [3:0] exp_y;
        string      name;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    dmux_1to4 u_dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .i_in   (i_in),
        .s      (s),
        .y      (y)
    );

    dmux_1to4 #(
        .SEL_W  (3),
        .DATA_W (4)
    ) u_dut_wide (
        .clk    (clk),
        .rst    (rst_w),
        .enable (enable_w),
        .i_in   (i_in_w),
        .s      (s_w),
        .y      (y_w)
    );

    task automatic check(input string name, input logic [31:0] actual);
        logic [31:0] expected;
        expected = exp_q.pop_front();
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic step_narrow(input string name, input logic [3:0] exp_y);
        exp_q.push_back({28'd0, exp_y});
        @(posedge clk);
        #1;
        check(name, {28'd0, y});
    endtask

    task automatic step_wide(input string name, input logic [31:0] exp_y);
        exp_q.push_back(exp_y);
        @(posedge clk);
        #1;
        check(name, y_w);
    endtask

    task automatic add(input logic r, input logic e, input logic d,
                       input logic [1:0] sel, input logic [3:0] ex, input string n);
        vec_t v;
        v.rst = r; v.enable = e; v.i_in = d; v.s = sel; v.exp_y = ex; v.name = n;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; i_in = 1'b1; s = 2'd2;
        rst_w = 1'b1; enable_w = 1'b0; i_in_w = 4'h0; s_w = 3'd0;

        add(1, 1, 1, 2'd2, 4'b0000, "reset_edge1");
        add(1, 1, 1, 2'd2, 4'b0000, "reset_edge2");
        add(0, 1, 1, 2'd2, 4'b0100, "reset_release");
        for (int k = 0; k < 4; k++) add(0, 0, 1, 2'(k), 4'b0000, "disable_sweep");
        for (int k = 0; k < 4; k++) add(0, 1, 1, 2'(k), 4'(1 << k), "route_sweep");
        for (int k = 0; k < 4; k++) add(0, 1, 0, 2'(k), 4'b0000, "zero_data");
        add(0, 1, 1, 2'd3, 4'b1000, "data_toggle");
        add(0, 1, 1, 2'd1, 4'b0010, "lane_switch_3to1");
        add(0, 0, 1, 2'd1, 4'b0000, "enable_drop");
        add(0, 1, 1, 2'd1, 4'b0010, "enable_restore");

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; enable = vecs[i].enable;
            i_in = vecs[i].i_in; s = vecs[i].s;
            step_narrow(vecs[i].name, vecs[i].exp_y);
        end

        // Mid-cycle select change only takes effect at the next edge.
        enable = 1'b1; i_in = 1'b1; s = 2'd0;
        step_narrow("mid_setup", 4'b0001);
        #2 s = 2'd1;
        #1;
        exp_q.push_back(32'h1);
        check("mid_hold", {28'd0, y});
        step_narrow("mid_update", 4'b0010);

        // Reset while a lane is active, then resume with no dead cycle.
        rst = 1'b1;
        step_narrow("reset_active", 4'b0000);
        rst = 1'b0; s = 2'd3;
        step_narrow("resume_after_reset", 4'b1000);

        // Widened instance: SEL_W=3, DATA_W=4.
        step_wide("wide_reset", 32'h0000_0000);
        rst_w = 1'b0; enable_w = 1'b1; i_in_w = 4'hA; s_w = 3'd5;
        step_wide("wide_lane5", 32'h00A0_0000);
        i_in_w = 4'hF; s_w = 3'd7;
        step_wide("wide_lane7", 32'hF000_0000);
        i_in_w = 4'h5; s_w = 3'd0;
        step_wide("wide_lane0", 32'h0000_0005);
        enable_w = 1'b0;
        step_wide("wide_disable", 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
